// File: rtl/int_controller.sv
// Prioritised interrupt controller: edge capture, mask/global enable, lowest-index select, entry sequencing to RETI.
// Optional INT_CTRL_IRQ_SYNC_EN adds a two-flop synchronizer on every irq line ahead of edge detection.
module int_controller #(
    parameter int unsigned NUM_SRC  = 4,
    parameter logic [9:0]  VEC_BASE = 10'h3F8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               gie_set,
    input  logic               gie_clr,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               pipe_ready,
    input  logic               reti,
    output logic               int_req,
    output logic               vec_load,
    output logic [9:0]         vec_addr,
    output logic [2:0]         int_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ENTRY0,
        ST_ENTRY1,
        ST_SERVICE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               gie_q, gie_d;
    logic [2:0]         int_id_q, int_id_d;
    logic [NUM_SRC-1:0] irq_prev_q;
    logic [NUM_SRC-1:0] irq_src;
    logic [NUM_SRC-1:0] irq_rise;
    logic [NUM_SRC-1:0] eligible;
    logic               entry_take;
    logic               reti_take;

`ifdef INT_CTRL_IRQ_SYNC_EN
    logic [NUM_SRC-1:0] irq_sync1_q, irq_sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_sync1_q <= '0;
            irq_sync2_q <= '0;
        end else begin
            irq_sync1_q <= irq;
            irq_sync2_q <= irq_sync1_q;
        end
    end

    assign irq_src = irq_sync2_q;
`else
    assign irq_src = irq;
`endif

    assign irq_rise = irq_src & ~irq_prev_q;
    assign eligible = pending_q & mask_q;

    // Fixed priority: the lowest-numbered eligible source wins.
    function automatic logic [2:0] lowest_index(input logic [NUM_SRC-1:0] vec);
        logic [2:0] idx;
        idx = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        int_id_d   = int_id_q;
        pending_d  = pending_q;
        gie_d      = gie_q;
        mask_d     = mask_we ? mask_wdata : mask_q;
        entry_take = 1'b0;
        reti_take  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gie_q && (|eligible)) begin
                    state_d  = ST_REQ;
                    int_id_d = lowest_index(eligible);
                end
            end
            ST_REQ: begin
                // A CLI retiring while the request is outstanding withdraws it.
                if (gie_clr) begin
                    state_d = ST_IDLE;
                end else if (pipe_ready) begin
                    state_d    = ST_ENTRY0;
                    entry_take = 1'b1;
                end
            end
            ST_ENTRY0: state_d = ST_ENTRY1;
            ST_ENTRY1: state_d = ST_SERVICE;
            ST_SERVICE: begin
                if (reti) begin
                    state_d   = ST_IDLE;
                    reti_take = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (entry_take) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (int_id_q == 3'(i)) begin
                    pending_d[i] = 1'b0;
                end
            end
        end
        // Applied after the entry clear so a fresh edge on the serviced source is kept.
        pending_d = pending_d | irq_rise;

        if (gie_set)    gie_d = 1'b1;
        if (reti_take)  gie_d = 1'b1;
        if (gie_clr)    gie_d = 1'b0;
        if (entry_take) gie_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            mask_q     <= '0;
            gie_q      <= 1'b0;
            int_id_q   <= '0;
            irq_prev_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q    <= state_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            gie_q      <= gie_d;
            int_id_q   <= int_id_d;
            irq_prev_q <= irq_src;
        end
    end

    assign int_req    = (state_q == ST_REQ);
    assign vec_load   = (state_q == ST_ENTRY1);
    assign in_service = (state_q == ST_SERVICE);
    assign int_id     = int_id_q;
    assign pending    = pending_q;
    assign vec_addr   = VEC_BASE + {7'b0, int_id_q};

endmodule

// File: doc/int_controller.md
# int_controller

Prioritised interrupt controller for the pipelined RAT core. It captures rising edges on up to `NUM_SRC` interrupt lines, applies a per-source mask and a global enable, and selects the lowest-numbered pending source. It then sequences interrupt entry into the pipeline with a request/ready handshake, a two-cycle flush window and a vector PC load, and holds in-service until `RETI`. It sits between the external IRQ lines and the hazard/flush controller (`int_req` drives that controller's `interrupt` input) and the PC load path.

## Interface
- `NUM_SRC`, 4: number of interrupt sources; legal range 1..8.
- `VEC_BASE`, 10'h3F8: vector address of source 0; source i vectors to `VEC_BASE + i`.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `reset_n` input 1: asynchronous, active-low reset.
- `irq` input NUM_SRC: interrupt lines, rising-edge sensitive.
- `gie_set` input 1: SEI retired; sets the global enable.
- `gie_clr` input 1: CLI retired; clears the global enable.
- `mask_we` input 1: write the mask register.
- `mask_wdata` input NUM_SRC: new mask value; 1 = source enabled.
- `pipe_ready` input 1: pipeline able to take an interrupt (hazard controller in CHECK, no stall, no branch/return flush active).
- `reti` input 1: RETI retired.
- `int_req` output 1: interrupt request to the hazard controller.
- `vec_load` output 1: one-cycle PC load strobe.
- `vec_addr` output 10: vector address, valid while `vec_load` = 1.
- `int_id` output 3: ID of the selected or in-service source.
- `in_service` output 1: a handler is executing.
- `pending` output NUM_SRC: latched pending bits.

## Operation
- Edge capture: `irq_prev` is registered every cycle. `pending[i]` is set at the edge where `irq[i] & ~irq_prev[i]` is true. Setting does not depend on the mask or on `gie`.
- Mask register: loaded from `mask_wdata` on `mask_we`.
- Global enable `gie`:
  - Set by `gie_set`, cleared by `gie_clr`; clear wins if both are asserted.
  - Cleared automatically on interrupt entry and set by `reti` while in SERVICE.
- States:
  - IDLE: if `gie` and `|(pending & mask)`, move to REQ. In the same edge, latch `int_id` = lowest set index of `pending & mask`.
  - REQ: `int_req` = 1. If `pipe_ready`, move to ENTRY0; in that edge clear `pending[int_id]` and clear `gie`. Otherwise hold REQ with `int_id` frozen. If `gie_clr` is asserted while in REQ, return to IDLE; `pending` is untouched.
  - ENTRY0: pipeline flush bubble 1. Move to ENTRY1.
  - ENTRY1: flush bubble 2. Assert `vec_load` with `vec_addr = VEC_BASE + int_id`. Move to SERVICE.
  - SERVICE: `in_service` = 1. On `reti`, set `gie` and move to IDLE. New edges continue to set pending bits.
- Simultaneous events:
  - A pending bit cleared on entry while a new edge arrives on the same source: set wins, so the new event is kept.
  - `reti` outside SERVICE: ignored.
  - `mask_we` while in REQ: does not change the already-latched `int_id`.
- Width: `vec_addr` is computed modulo 2^10; wrap-around from the addition is allowed and is not flagged.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE
  - `pending`, `mask`, `gie`, `irq_prev` all 0
  - `int_req` 0, `vec_load` 0, `int_id` 0, `in_service` 0
  - `vec_addr` = `VEC_BASE`
- Reset asserted mid-entry or mid-service aborts immediately with no `vec_load` pulse.
- Edge to `int_req`: `irq` first sampled high at edge N gives pending visible after N and `int_req` = 1 after N+1, provided `gie` and the mask bit are set.
- `int_req` to `vec_load`: if `pipe_ready` is sampled at edge M, `vec_load` is high during the cycle after M+1, for exactly one cycle. `in_service` rises after M+2.
- All outputs are registered state decodes; there is no combinational path from any input to any output.

## Configuration
- `INT_CTRL_IRQ_SYNC_EN`
  - Defined: each `irq` bit passes through a two-flop synchronizer before edge detection. Edge-to-`int_req` latency grows by 2 cycles. Synchronizer flops reset to 0.
  - Undefined: `irq` is assumed synchronous to `clk` and feeds edge detection directly.

## Test plan
- Reset, then set mask = 4'b1111 and `gie` = 1; pulse `irq[2]` with `pipe_ready` = 1. Expect: `int_req` 2 cycles after the edge; `vec_load` with `vec_addr` = 10'h3FA; `in_service` = 1; `gie` = 0; `pending[2]` = 0.
- Raise `irq[3]` and `irq[1]` on the same cycle. Expect: `int_id` = 1 serviced first. After `reti`, `int_id` = 3 serviced with `vec_addr` = 10'h3FB.
- Hold `pipe_ready` = 0 for 5 cycles while in REQ. Expect: `int_req` held high for 5 cycles, no `vec_load`. Raise `pipe_ready`: `vec_load` follows 2 cycles later.
- Set mask = 0 and pulse `irq[0]`. Expect: `pending[0]` = 1 and no `int_req`. Write mask = 1: `int_req` 1 cycle later.
- Deassert `reset_n` during ENTRY0. Expect: all outputs 0 immediately, `vec_addr` = 10'h3F8, no `vec_load` after release.
- With `INT_CTRL_IRQ_SYNC_EN` defined: edge-to-`int_req` latency is 4 cycles instead of 2.
